// File: rtl/mac_accum_ctrl.sv
// Dot-product accumulation controller for a pipelined adder tree: tracks in-flight
// chunk tags, accumulates returned sums per vector and queues results in a FWFT FIFO.
module mac_accum_ctrl #(
  parameter int SUM_W     = 20,
  parameter int ACC_W     = 32,
  parameter int TREE_LAT  = 4,
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             tree_valid_o,
  input  logic [SUM_W-1:0] tree_sum_i,
  input  logic             tree_sum_valid_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic [CNT_W-1:0] res_chunks_o,
  output logic             err_o
);

  localparam int TAG_D = TREE_LAT + 1;
  localparam int TPW   = (TAG_D > 1) ? $clog2(TAG_D) : 1;
  localparam int TCW   = $clog2(TAG_D + 1);
  localparam int RPW   = $clog2(RES_DEPTH);
  localparam int RCW   = $clog2(RES_DEPTH + 1);

  localparam logic [TPW-1:0] TAG_PTR_LAST = TPW'(TAG_D - 1);
  localparam logic [RPW-1:0] RES_PTR_LAST = RPW'(RES_DEPTH - 1);
  localparam logic [TCW-1:0] TAG_FULL     = TCW'(TAG_D);
  localparam logic [RCW-1:0] RES_FULL     = RCW'(RES_DEPTH);

  // Handshakes: a chunk moves on in_valid_i && in_ready_o; a result moves on
  // res_valid_o && res_ready_i; the tree answers every issued chunk, in order.

  logic [TAG_D-1:0] tag_mem;
  logic [TPW-1:0]   tag_wr_ptr, tag_rd_ptr;
  logic [TCW-1:0]   tag_cnt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] chunk_cnt;

  logic [ACC_W-1:0] res_data_mem [RES_DEPTH];
  logic [CNT_W-1:0] res_cnt_mem  [RES_DEPTH];
  logic [RPW-1:0]   res_wr_ptr, res_rd_ptr;
  logic [RCW-1:0]   res_fill;
  logic [RCW-1:0]   pend_cnt;
  logic             err_q;

  logic                    accept;
  logic                    sum_fire;
  logic                    spurious;
  logic                    head_last;
  logic                    res_wr;
  logic                    res_pop;
  logic signed [SUM_W-1:0] sum_s;
  logic [ACC_W-1:0]        acc_next;
  logic [CNT_W-1:0]        chunk_next;

  assign in_ready_o   = (tag_cnt < TAG_FULL) && (pend_cnt < RES_FULL);
  assign accept       = in_valid_i && in_ready_o;
  assign tree_valid_o = accept;

  // A sum with no outstanding tag is a protocol violation and is dropped.
  assign sum_fire  = tree_sum_valid_i && (tag_cnt != '0);
  assign spurious  = tree_sum_valid_i && (tag_cnt == '0);
  assign head_last = tag_mem[tag_rd_ptr];

  assign sum_s      = tree_sum_i;
  assign acc_next   = acc + ACC_W'(sum_s);
  assign chunk_next = chunk_cnt + 1'b1;

  assign res_wr  = sum_fire && head_last;
  assign res_pop = res_valid_o && res_ready_i;

  assign res_valid_o  = (res_fill != '0);
  assign res_data_o   = res_data_mem[res_rd_ptr];
  assign res_chunks_o = res_cnt_mem[res_rd_ptr];
  assign err_o        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
      acc        <= '0;
      chunk_cnt  <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_fill   <= '0;
      pend_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept)
        tag_wr_ptr <= (tag_wr_ptr == TAG_PTR_LAST) ? '0 : tag_wr_ptr + 1'b1;
      if (sum_fire)
        tag_rd_ptr <= (tag_rd_ptr == TAG_PTR_LAST) ? '0 : tag_rd_ptr + 1'b1;

      case ({accept, sum_fire})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      // The last sum of a vector goes straight to the FIFO so the next vector starts from 0.
      if (sum_fire) begin
        if (head_last) begin
          acc       <= '0;
          chunk_cnt <= '0;
        end else begin
          acc       <= acc_next;
          chunk_cnt <= chunk_next;
        end
      end

      if (res_wr)
        res_wr_ptr <= (res_wr_ptr == RES_PTR_LAST) ? '0 : res_wr_ptr + 1'b1;
      if (res_pop)
        res_rd_ptr <= (res_rd_ptr == RES_PTR_LAST) ? '0 : res_rd_ptr + 1'b1;

      case ({res_wr, res_pop})
        2'b10:   res_fill <= res_fill + 1'b1;
        2'b01:   res_fill <= res_fill - 1'b1;
        default: res_fill <= res_fill;
      endcase

      case ({accept && in_last_i, res_pop})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase

      if (spurious)
        err_q <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wr_ptr] <= in_last_i;
    if (res_wr) begin
      res_data_mem[res_wr_ptr] <= acc_next;
      res_cnt_mem[res_wr_ptr]  <= chunk_next;
    end
  end

endmodule

// File: doc/mac_accum_ctrl.md
MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- SUM_W, 20, width of the adder-tree sum.
- ACC_W, 32, accumulator and result width (ACC_W >= SUM_W).
- TREE_LAT, 4, cycles from tree valid_i to sum_valid_o of the attached adder tree.
- RES_DEPTH, 4, result FIFO depth (>= 2).
- CNT_W, 16, chunk-count width.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid_i, in, 1, a chunk is presented on the tree data inputs.
- in_last_i, in, 1, the presented chunk is the final chunk of its vector.
- in_ready_o, out, 1, the controller accepts a chunk this cycle.
- tree_valid_o, out, 1, drives valid_i of the adder tree.
- tree_sum_i, in, SUM_W, signed sum from the adder tree.
- tree_sum_valid_i, in, 1, sum valid from the adder tree.
- res_valid_o, out, 1, a result is available.
- res_ready_i, in, 1, the consumer accepts the result.
- res_data_o, out, ACC_W, signed dot-product result.
- res_chunks_o, out, CNT_W, number of chunks accumulated into res_data_o.
- err_o, out, 1, sticky protocol error.

REQ-003 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be clk.

Function
REQ-004 A chunk SHALL be accepted when in_valid_i && in_ready_o, and tree_valid_o SHALL equal in_valid_i && in_ready_o combinationally.
REQ-005 in_ready_o SHALL be 1 iff tag_cnt < TREE_LAT+1 and pend_cnt < RES_DEPTH.
- tag_cnt: chunks issued whose sums have not yet returned.
- pend_cnt: accepted last-chunks whose results have not yet been popped.
REQ-006 Each accepted chunk SHALL push its in_last_i bit into an in-order tag FIFO of depth TREE_LAT+1.
- Each tree_sum_valid_i SHALL pop one tag.
REQ-007 A returned sum SHALL be sign-extended to ACC_W and added to the accumulator; chunk_cnt SHALL increment.
REQ-008 If the popped tag is last, the block SHALL write acc+sum and chunk_cnt+1 into the result FIFO in the same cycle.
- The accumulator and chunk_cnt SHALL then clear to 0.
- The next vector SHALL therefore start from 0 with no bubble.
REQ-009 Accumulation SHALL wrap in two's complement with no saturation; chunk_cnt SHALL also wrap.
REQ-010 The result FIFO SHALL be first-word-fall-through.
- res_valid_o = FIFO not empty.
- res_data_o and res_chunks_o come from the FIFO head.
- A pop occurs on res_valid_o && res_ready_i.
REQ-011 Latency SHALL be as follows.
- A last chunk accepted at cycle t returns its sum at t+TREE_LAT.
- Its result SHALL then be visible at t+TREE_LAT+1 when the FIFO is empty.
REQ-012 Simultaneous events SHALL be handled as follows.
- An accept of a last chunk together with a result pop SHALL leave pend_cnt unchanged.
- An issue together with a sum return SHALL leave tag_cnt unchanged.
- A FIFO write together with a pop on a full FIFO SHALL both succeed.
REQ-013 Outputs SHALL hold stable while res_valid_o && !res_ready_i.
REQ-014 err_o SHALL set and stay set until reset on a tree_sum_valid_i while tag_cnt == 0.
- That sum SHALL be discarded with no state change.
REQ-015 pend_cnt bounding SHALL guarantee that the result FIFO never overflows; no write SHALL ever be dropped.

Reset
REQ-016 While rst_n is low, the following SHALL be cleared.
- accumulator, chunk_cnt, tag_cnt, pend_cnt and FIFO pointers SHALL clear to 0.
- res_valid_o SHALL be 0 and err_o SHALL be 0.
- in_ready_o SHALL be 1 and tree_valid_o SHALL follow in_valid_i.
REQ-017 Reset asserted mid-vector SHALL discard all partial sums, tags and queued results.
- Sums returning after reset release with tag_cnt == 0 SHALL set err_o.

Verification
REQ-018 The bench SHALL cover the following scenarios.
- Single vector: 3 chunks with returned sums 10, -4, 7 (last on the third) -> one result, res_data_o = 13, res_chunks_o = 3, visible 5 cycles after the third accept (TREE_LAT = 4).
- Back-to-back: vectors with sums {5} and {-2, -3} issued on consecutive cycles -> results 5/1 then -5/2 in order, with no bubble on in_ready_o.
- Backpressure: res_ready_i = 0 and 4 single-chunk vectors -> in_ready_o drops after the 4th last accept; after one pop, exactly one more vector is accepted.
- Wrap: with ACC_W = 32, sums 0x7FFFF repeated until 2^31 is crossed -> result wraps negative and err_o stays 0.
- Spurious sum: tree_sum_valid_i pulsed with nothing issued -> err_o = 1, no result produced, and subsequent vectors still correct.
- Reset mid-vector: rst_n pulsed after 2 of 3 chunks -> res_valid_o = 0 and in_ready_o = 1; a fresh vector {1, 2} yields 3/2.
